// File: rtl/picobello_pkg.sv
// Shared mesh-level constants and the tile reset sequencer state type.
// Tile count is derived from the mesh composition so that the sequencer tracks the floorplan.
package picobello_pkg;

  localparam int unsigned NumClusters   = 16;
  localparam int unsigned NumMemTiles   = 4;
  localparam int unsigned NumDummyTiles = 2;
  // The two extra tiles are the FhG SPU tile and the Cheshire-side tile.
  localparam int unsigned NumSeqTiles   = NumClusters + NumMemTiles + NumDummyTiles + 2;

  localparam int unsigned DefaultHoldCycles    = 8;
  localparam int unsigned DefaultGapCycles     = 4;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    SCAN,
    WAIT_RDY,
    GAP,
    DONE
  } rst_seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tile_rst_seq_timer.sv
// Loadable down-counter shared by the hold, gap and ready-timeout phases of the sequencer.
// It stops at zero and reports that through zero_o.
module tile_rst_seq_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] value_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tile_rst_sequencer.sv
// Releases mesh tiles from reset and NoC isolation one at a time, in index order.
// Optional ready timeout with error reporting is enabled by defining PB_RST_SEQ_TIMEOUT_EN.
module tile_rst_sequencer
  import picobello_pkg::*;
#(
  parameter  int unsigned NumTiles      = NumSeqTiles,
  parameter  int unsigned HoldCycles    = DefaultHoldCycles,
  parameter  int unsigned GapCycles     = DefaultGapCycles,
  parameter  int unsigned TimeoutCycles = DefaultTimeoutCycles,
  localparam int unsigned TileW         = (NumTiles > 1) ? $clog2(NumTiles) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [NumTiles-1:0] tile_en_i,
  input  logic [NumTiles-1:0] tile_ready_i,
  output logic [NumTiles-1:0] tile_rst_no,
  output logic [NumTiles-1:0] tile_iso_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [TileW-1:0]    err_tile_o
);

  localparam int unsigned CntMax = max_u(max_u(HoldCycles, GapCycles), TimeoutCycles);
  localparam int unsigned CntW   = (CntMax > 0) ? $clog2(CntMax + 1) : 1;
  localparam int unsigned IdxW   = $clog2(NumTiles + 1);

  localparam logic [CntW-1:0] HoldLoad = CntW'((HoldCycles > 0) ? HoldCycles - 1 : 0);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GapCycles > 0) ? GapCycles - 1 : 0);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumTiles);
`ifdef PB_RST_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLoad = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
`endif

  rst_seq_state_e      state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [TileW-1:0]    cur;
  logic [NumTiles-1:0] en_q, en_d;
  logic [NumTiles-1:0] rst_q, rst_d;
  logic [NumTiles-1:0] iso_q, iso_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load;
  logic [CntW-1:0]     load_val;
  logic                zero;
  logic                advance;
`ifdef PB_RST_SEQ_TIMEOUT_EN
  logic                err_q, err_d;
  logic [TileW-1:0]    err_tile_q, err_tile_d;
`endif

  assign cur = idx_q[TileW-1:0];

  tile_rst_seq_timer #(
    .CntW(CntW)
  ) i_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .value_i(load_val),
    .zero_o (zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    en_d     = en_q;
    rst_d    = rst_q;
    iso_d    = iso_q;
    busy_d   = busy_q;
    done_d   = done_q;
    load     = 1'b0;
    load_val = '0;
    advance  = 1'b0;
`ifdef PB_RST_SEQ_TIMEOUT_EN
    err_d      = err_q;
    err_tile_d = err_tile_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          en_d   = tile_en_i;
          rst_d  = '0;
          iso_d  = '1;
          busy_d = 1'b1;
          done_d = 1'b0;
          idx_d  = '0;
`ifdef PB_RST_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
          err_tile_d = '0;
`endif
          if (HoldCycles > 0) begin
            load     = 1'b1;
            load_val = HoldLoad;
            state_d  = HOLD;
          end else begin
            state_d = SCAN;
          end
        end
      end
      HOLD: begin
        if (zero) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == LastIdx) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!en_q[cur]) begin
          idx_d = idx_q + IdxW'(1);
        end else begin
          rst_d[cur] = 1'b1;
          state_d    = WAIT_RDY;
`ifdef PB_RST_SEQ_TIMEOUT_EN
          load     = 1'b1;
          load_val = TimeoutLoad;
`endif
        end
      end
      WAIT_RDY: begin
        // Ready wins over a timeout expiring in the same cycle.
        if (tile_ready_i[cur]) begin
          iso_d[cur] = 1'b0;
          advance    = 1'b1;
`ifdef PB_RST_SEQ_TIMEOUT_EN
        end else if (zero) begin
          rst_d[cur] = 1'b0;
          err_d      = 1'b1;
          err_tile_d = cur;
          advance    = 1'b1;
`endif
        end
        if (advance) begin
          if (GapCycles > 0) begin
            load     = 1'b1;
            load_val = GapLoad;
            state_d  = GAP;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = SCAN;
          end
        end
      end
      GAP: begin
        if (zero) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      rst_q   <= '0;
      iso_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PB_RST_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      err_tile_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      rst_q   <= rst_d;
      iso_q   <= iso_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PB_RST_SEQ_TIMEOUT_EN
      err_q      <= err_d;
      err_tile_q <= err_tile_d;
`endif
    end
  end

  assign tile_rst_no = rst_q;
  assign tile_iso_o  = iso_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef PB_RST_SEQ_TIMEOUT_EN
  assign err_o       = err_q;
  assign err_tile_o  = err_tile_q;
`else
  assign err_o       = 1'b0;
  assign err_tile_o  = '0;
`endif

endmodule

// File: tb/tb_tile_rst_sequencer.sv
// Self-checking bench for tile_rst_sequencer: a schedule model predicts per-tile release/accept times.
// Define PB_RST_SEQ_TIMEOUT_EN to also exercise the ready-timeout scenario.
module tb_tile_rst_sequencer;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int G  = 4;
  localparam int T  = 16;
  localparam int TW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  tile_en;
  logic [N-1:0]  tile_ready;
  logic [N-1:0]  tile_rst_n;
  logic [N-1:0]  tile_iso;
  logic          busy;
  logic          done;
  logic          err;
  logic [TW-1:0] err_tile;

  tile_rst_sequencer #(
    .NumTiles     (N),
    .HoldCycles   (H),
    .GapCycles    (G),
    .TimeoutCycles(T)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .tile_en_i   (tile_en),
    .tile_ready_i(tile_ready),
    .tile_rst_no (tile_rst_n),
    .tile_iso_o  (tile_iso),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .err_tile_o  (err_tile)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: times are counted in clock edges since the accepted start edge (start edge = 0).
  bit           reset_mode = 1'b1;
  bit           armed      = 1'b0;
  int           k          = 0;
  int           done_k     = 0;
  int           rel_k[N];
  int           acc_k[N];
  int           to_k[N];
  int           lat[N];
  logic [N-1:0] m_en;
  logic [N-1:0] junk_rdy;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Each enabled tile costs scan + release + ready latency + accept + gap; disabled tiles one scan cycle.
  task automatic plan_sequence();
    int p;
    p = H;
    for (int i = 0; i < N; i++) begin
      rel_k[i] = -1;
      acc_k[i] = -1;
      to_k[i]  = -1;
      if (!m_en[i]) begin
        p = p + 1;
      end else begin
        rel_k[i] = p + 1;
`ifdef PB_RST_SEQ_TIMEOUT_EN
        if (lat[i] < 0 || lat[i] >= T) begin
          to_k[i] = p + T + 1;
          p = p + T + 1 + G;
        end else
`endif
        begin
          acc_k[i] = p + 2 + lat[i];
          p = p + 2 + lat[i] + G;
        end
      end
    end
    done_k = p + 1;
  endtask

  task automatic compare_all();
    logic [N-1:0]  e_rst;
    logic [N-1:0]  e_iso;
    logic          e_busy;
    logic          e_done;
    logic          e_err;
    logic [TW-1:0] e_et;
    e_rst  = '0;
    e_iso  = '1;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    e_et   = '0;
    if (!reset_mode) begin
      for (int i = 0; i < N; i++) begin
        e_rst[i] = (rel_k[i] >= 0) && (k >= rel_k[i]) && !((to_k[i] >= 0) && (k >= to_k[i]));
        e_iso[i] = !((acc_k[i] >= 0) && (k >= acc_k[i]));
        if ((to_k[i] >= 0) && (k >= to_k[i])) begin
          e_err = 1'b1;
          e_et  = TW'(i);
        end
      end
      e_busy = (k < done_k);
      e_done = (k >= done_k);
    end
    checkOutput("tile_rst_no", 32'(tile_rst_n), 32'(e_rst));
    checkOutput("tile_iso_o", 32'(tile_iso), 32'(e_iso));
    checkOutput("busy_o", 32'(busy), 32'(e_busy));
    checkOutput("done_o", 32'(done), 32'(e_done));
    checkOutput("err_o", 32'(err), 32'(e_err));
    checkOutput("err_tile_o", 32'(err_tile), 32'(e_et));
  endtask

  // Model update on each edge, compare and ready response on the following falling edge.
  initial begin
    tile_ready = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        reset_mode = 1'b1;
        armed      = 1'b1;
      end else if (start && (reset_mode || k >= done_k + 1)) begin
        m_en = tile_en;
        plan_sequence();
        k          = 0;
        reset_mode = 1'b0;
      end else begin
        k++;
      end
      @(negedge clk);
      if (armed) compare_all();
      for (int i = 0; i < N; i++) begin
        tile_ready[i] = junk_rdy[i] |
                        (!reset_mode && lat[i] >= 0 && rel_k[i] >= 0 && k >= rel_k[i] + lat[i]);
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] en);
    tile_en = en;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (reset_mode || k < done_k + 1) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL wait_done: sequence end not reached within 3000 cycles");
        break;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    tile_en  = '0;
    junk_rdy = '0;
    for (int i = 0; i < N; i++) lat[i] = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle after reset");
    repeat (100) @(negedge clk);
    checkOutput("idle_iso", 32'(tile_iso), 32'hF);

    $display("[TB] all tiles, ready one cycle after release, stray start mid-sequence");
    applyStimulus(4'b1111);
    checkOutput("plan_done_k", 32'(done_k), 32'd37);
    checkOutput("plan_rel3", 32'(rel_k[3]), 32'd30);
    repeat (16) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    checkOutput("all_rst", 32'(tile_rst_n), 32'hF);
    checkOutput("all_iso", 32'(tile_iso), 32'h0);
    checkOutput("all_done", 32'(done), 32'd1);

    $display("[TB] restart after completion, then reset during gap after tile 1");
    applyStimulus(4'b1111);
    checkOutput("restart_rst", 32'(tile_rst_n), 32'h0);
    checkOutput("restart_iso", 32'(tile_iso), 32'hF);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid_iso", 32'(tile_iso), 32'hF);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    $display("[TB] sparse enable 1010 with immediate ready and stray readies");
    for (int i = 0; i < N; i++) lat[i] = 0;
    junk_rdy = 4'b0101;
    applyStimulus(4'b1010);
    tile_en = 4'b1111;
    checkOutput("plan_sparse_done_k", 32'(done_k), 32'd23);
    wait_done();
    checkOutput("sparse_rst", 32'(tile_rst_n), 32'hA);
    checkOutput("sparse_iso", 32'(tile_iso), 32'h5);
    checkOutput("sparse_done", 32'(done), 32'd1);
    junk_rdy = '0;

`ifdef PB_RST_SEQ_TIMEOUT_EN
    $display("[TB] tile 2 never ready, timeout path");
    for (int i = 0; i < N; i++) lat[i] = 1;
    lat[2] = -1;
    applyStimulus(4'b1111);
    checkOutput("plan_to_done_k", 32'(done_k), 32'd51);
    wait_done();
    checkOutput("to_err", 32'(err), 32'd1);
    checkOutput("to_err_tile", 32'(err_tile), 32'd2);
    checkOutput("to_rst", 32'(tile_rst_n), 32'hB);
    checkOutput("to_iso", 32'(tile_iso), 32'h4);
    checkOutput("to_done", 32'(done), 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
